branch_fetch_pc_unit: RTL and testbench
=======================================

Name: branch_fetch_pc_unit

Overview:
Fetch-stage next-PC generator sitting directly upstream of the 2-bit-counter branch predictor.
- Drives the predictor's read index from the current PC and selects the next PC from the prediction.
- Queues every predicted branch in flight.
- On EX-stage resolution, produces the predictor update (en / write index / was_taken) and redirects fetch on mispredict.

Parameters:
LOWER, 5, predictor index width; index = pc[LOWER+1:2]
DEPTH, 4, in-flight branch queue entries (power of 2, >=2)
RESET_PC, 64'h0, PC value after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  downstream fetch stall; holds PC, blocks push
is_branch  in  1  predecode: instruction at pc is a conditional branch (combinational, same cycle)
pred_taken  in  1  predictor output for pred_idx (combinational, same cycle)
pred_target  in  64  predicted target for pred_idx
res_valid  in  1  EX resolves oldest in-flight branch this cycle
res_taken  in  1  actual branch outcome
res_target  in  64  actual taken target
pc  out  64  current fetch PC (registered)
pred_idx  out  LOWER  predictor read index = pc[LOWER+1:2] (combinational)
fetch_fire  out  1  instruction at pc accepted this cycle (combinational)
upd_en  out  1  predictor update strobe (registered, 1-cycle pulse)
upd_idx  out  LOWER  predictor write index
upd_taken  out  1  was_taken for predictor
redirect  out  1  mispredict redirect pulse (registered, 1 cycle)
count  out  clog2(DEPTH)+1  queue occupancy
err  out  1  sticky: res_valid seen with empty queue

Behaviour:
- Reset (rst=1 at edge), regardless of other inputs:
  - pc=RESET_PC; queue cleared, count=0.
  - upd_en=0, upd_idx=0, upd_taken=0, redirect=0, err=0.
  - A reset mid-operation discards all in-flight entries.
- fetch_fire = !stall && !(is_branch && count==DEPTH); it is combinational on the current count, with no same-cycle pop bypass.
- Fall-through: fallthrough = pc + 4, modulo 2^64.
- Predicted next: pnext = (is_branch && pred_taken) ? pred_target : fallthrough.
- Push: when fetch_fire && is_branch, push {idx=pred_idx, pnext, fallthrough} at the tail.
- PC update (no mispredict this cycle): fetch_fire -> pc <= pnext; otherwise pc holds.
- Resolution: when res_valid && count>0:
  - Pop the head entry.
  - actual = res_taken ? res_target : head.fallthrough.
  - mispredict = (actual != head.pnext), a full 64-bit compare.
  - Next cycle: upd_en=1, upd_idx=head.idx, upd_taken=res_taken. The update strobe fires on every resolution, correct or not.
- Mispredict:
  - pc <= actual.
  - The entire queue is flushed (count <= 0), since younger entries are wrong-path.
  - Any same-cycle push is dropped.
  - redirect=1 for exactly the next cycle.
  - Mispredict has priority over the fetch PC update and over stall.
- Correct prediction:
  - Head popped only.
  - Simultaneous push+pop: count unchanged, and the push lands at the tail after the pop.
- res_valid with count==0: ignored (no pop, no upd_en, no redirect); err <= 1, sticky until rst.
- stall never blocks resolution, update or redirect.
- Queue: circular with head/tail pointers that wrap modulo DEPTH; count tracked separately to distinguish full from empty.
- Latency:
  - pred_idx to pc selection is 0 cycles (same cycle).
  - Resolution to upd_en/redirect is 1 cycle.

Test Plan:
- Reset, then no branches:
  - Release rst with RESET_PC=0, is_branch=0, stall=0 for 3 cycles -> pc 0x0,0x4,0x8,0xC.
  - pred_idx 0,1,2,3; upd_en=0; count=0.
- Predicted-taken, correct:
  - At pc=0x40, is_branch=1, pred_taken=1, pred_target=0x100 -> pred_idx=16; next pc=0x100; count=1.
  - Later res_valid=1, res_taken=1, res_target=0x100 -> next cycle upd_en=1, upd_idx=16, upd_taken=1, redirect=0; count=0.
- Predicted not-taken, actually taken:
  - At pc=0x40, is_branch=1, pred_taken=0 -> pc=0x44.
  - Push two more branches (count=3), then res_valid=1, res_taken=1, res_target=0x200 -> next cycle pc=0x200, redirect=1, count=0, upd_en=1, upd_taken=0->1 reported as upd_taken=1.
- Queue full:
  - Push DEPTH=4 branches without resolution; 5th branch at pc=P with stall=0 -> fetch_fire=0, pc holds P.
  - Same cycle res_valid correct -> count 3 next cycle; branch accepted the cycle after.
- Simultaneous mispredict and push:
  - res_valid mispredict (actual=0x300) while is_branch=1, fetch_fire=1 -> push dropped, count=0, pc=0x300.
  - stall=1 in the same scenario still redirects.
- Error and reset mid-op:
  - res_valid=1 with count=0 -> err=1, no upd_en; err stays 1.
  - Assert rst with count=2 -> err=0, count=0, pc=RESET_PC, upd_en=0.

Source files
------------

// File: rtl/branch_fetch_pc_unit.sv
// branch_fetch_pc_unit: fetch next-PC select, in-flight branch queue, predictor update and mispredict redirect
module branch_fetch_pc_unit #(
   parameter int          LOWER    = 5,
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall,
   input  logic                       is_branch,
   input  logic                       pred_taken,
   input  logic [63:0]                pred_target,
   input  logic                       res_valid,
   input  logic                       res_taken,
   input  logic [63:0]                res_target,
   output logic [63:0]                pc,
   output logic [LOWER-1:0]           pred_idx,
   output logic                       fetch_fire,
   output logic                       upd_en,
   output logic [LOWER-1:0]           upd_idx,
   output logic                       upd_taken,
   output logic                       redirect,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       err
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [LOWER-1:0] q_idx [DEPTH];
   logic [63:0]      q_pn  [DEPTH];
   logic [63:0]      q_ft  [DEPTH];
   logic [AW-1:0]    head, tail;
   logic [63:0]      fallthrough, pnext, actual;
   logic             push, pop, mispredict;
   always_comb begin
      pred_idx    = pc[LOWER+1:2];
      fetch_fire  = !stall && !(is_branch && count == CW'(DEPTH));
      fallthrough = pc + 64'd4;
      pnext       = (is_branch && pred_taken) ? pred_target : fallthrough;
      push        = fetch_fire && is_branch;
      pop         = res_valid && count != '0;
      actual      = res_taken ? res_target : q_ft[head];
      mispredict  = pop && actual != q_pn[head];
   end
   // Entry storage needs no reset: count alone decides which slots are live.
   always_ff @(posedge clk) begin
      if (push) begin
         q_idx[tail] <= pred_idx;
         q_pn[tail]  <= pnext;
         q_ft[tail]  <= fallthrough;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= RESET_PC;
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         upd_en    <= 1'b0;
         upd_idx   <= '0;
         upd_taken <= 1'b0;
         redirect  <= 1'b0;
         err       <= 1'b0;
      end else begin
         upd_en   <= pop;
         redirect <= mispredict;
         err      <= err || (res_valid && count == '0);
         if (pop) begin
            upd_idx   <= q_idx[head];
            upd_taken <= res_taken;
         end
         if (mispredict) begin
            pc    <= actual;
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (fetch_fire) pc <= pnext;
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end
endmodule

// File: tb/tb_branch_fetch_pc_unit.sv
// tb_branch_fetch_pc_unit: directed scenarios plus randomized run against a queue-based reference model
module tb_branch_fetch_pc_unit;
   localparam int LOWER = 5;
   localparam int DEPTH = 4;
   logic        clk = 0, rst = 0, stall = 0, is_branch = 0, pred_taken = 0;
   logic [63:0] pred_target = 0, res_target = 0;
   logic        res_valid = 0, res_taken = 0;
   logic [63:0] pc;
   logic [4:0]  pred_idx, upd_idx;
   logic        fetch_fire, upd_en, upd_taken, redirect, err;
   logic [2:0]  count;
   int checks = 0, errors = 0;

   branch_fetch_pc_unit #(.LOWER(LOWER), .DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
      .clk(clk), .rst(rst), .stall(stall), .is_branch(is_branch), .pred_taken(pred_taken),
      .pred_target(pred_target), .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
      .pc(pc), .pred_idx(pred_idx), .fetch_fire(fetch_fire), .upd_en(upd_en), .upd_idx(upd_idx),
      .upd_taken(upd_taken), .redirect(redirect), .count(count), .err(err));

   always #5 clk = ~clk;

   typedef struct { logic [4:0] idx; logic [63:0] pn; logic [63:0] ft; } ent_t;
   ent_t        mq[$];
   logic [63:0] m_pc = 0;
   logic [4:0]  m_upd_idx = 0;
   logic        m_upd_en = 0, m_upd_taken = 0, m_redirect = 0, m_err = 0;

   task automatic model_step();
      ent_t e;
      logic [63:0] ft, pn, act;
      logic fire, mis;
      if (rst) begin
         m_pc = 0; mq.delete(); m_upd_en = 0; m_upd_idx = 0; m_upd_taken = 0; m_redirect = 0; m_err = 0;
         return;
      end
      fire = !stall && !(is_branch && mq.size() == DEPTH);
      ft = m_pc + 64'd4;
      pn = (is_branch && pred_taken) ? pred_target : ft;
      m_upd_en = 0; m_redirect = 0; mis = 0;
      if (res_valid && mq.size() == 0) m_err = 1;
      if (res_valid && mq.size() > 0) begin
         e = mq.pop_front();
         act = res_taken ? res_target : e.ft;
         m_upd_en = 1; m_upd_idx = e.idx; m_upd_taken = res_taken;
         if (act != e.pn) begin
            mis = 1; m_redirect = 1; mq.delete(); m_pc = act;
         end
      end
      if (!mis) begin
         if (fire && is_branch) mq.push_back('{m_pc[6:2], pn, ft});
         if (fire) m_pc = pn;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 0; stall = 0; is_branch = 0; pred_taken = 0; pred_target = 0;
      res_valid = 0; res_taken = 0; res_target = 0;
   endtask

   task automatic goto_pc(input logic [63:0] a);
      int n = 0;
      idle();
      while (pc !== a && n < 200) begin tick(); n++; end
      checks++; if (pc !== a) begin errors++; $display("FAIL goto_pc pc=%h want %h", pc, a); end
   endtask

   task automatic test_reset();
      idle(); rst = 1; tick(); rst = 0;
      checks++; if (pc !== 64'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
      checks++; if ({upd_en, upd_idx, upd_taken, redirect, err} !== 9'd0) begin errors++;
         $display("FAIL reset_outs got %b want 0", {upd_en, upd_idx, upd_taken, redirect, err}); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (pc !== 64'(4 * k)) begin errors++; $display("FAIL seq_pc got %h want %h", pc, 4 * k); end
         checks++; if (pred_idx !== 5'(k)) begin errors++; $display("FAIL seq_idx got %0d want %0d", pred_idx, k); end
         checks++; if (upd_en !== 1'b0 || count !== 3'd0) begin errors++;
            $display("FAIL seq_idle upd_en=%b count=%0d want 0 0", upd_en, count); end
         if (k < 3) tick();
      end
   endtask

   task automatic test_taken_correct();
      goto_pc(64'h40);
      is_branch = 1; pred_taken = 1; pred_target = 64'h100; #1;
      checks++; if (pred_idx !== 5'd16) begin errors++; $display("FAIL tc_idx got %0d want 16", pred_idx); end
      checks++; if (fetch_fire !== 1'b1) begin errors++; $display("FAIL tc_fire got %b want 1", fetch_fire); end
      tick();
      checks++; if (pc !== 64'h100 || count !== 3'd1) begin errors++;
         $display("FAIL tc_push pc=%h count=%0d want 100 1", pc, count); end
      idle(); tick();
      res_valid = 1; res_taken = 1; res_target = 64'h100; tick();
      checks++; if ({upd_en, upd_idx, upd_taken, redirect} !== {1'b1, 5'd16, 1'b1, 1'b0}) begin errors++;
         $display("FAIL tc_upd got en=%b idx=%0d tk=%b rd=%b want 1 16 1 0", upd_en, upd_idx, upd_taken, redirect); end
      checks++; if (count !== 3'd0 || pc !== 64'h108) begin errors++;
         $display("FAIL tc_after count=%0d pc=%h want 0 108", count, pc); end
      idle(); tick();
      checks++; if (upd_en !== 1'b0) begin errors++; $display("FAIL tc_pulse upd_en=%b want 0", upd_en); end
   endtask

   task automatic test_mispredict();
      idle(); rst = 1; tick();
      goto_pc(64'h40);
      is_branch = 1; pred_taken = 0; tick();
      checks++; if (pc !== 64'h44) begin errors++; $display("FAIL mp_nt pc=%h want 44", pc); end
      tick(); tick();
      checks++; if (count !== 3'd3 || pc !== 64'h4c) begin errors++;
         $display("FAIL mp_fill count=%0d pc=%h want 3 4c", count, pc); end
      idle(); res_valid = 1; res_taken = 1; res_target = 64'h200; tick();
      checks++; if (pc !== 64'h200 || redirect !== 1'b1 || count !== 3'd0) begin errors++;
         $display("FAIL mp_redir pc=%h rd=%b count=%0d want 200 1 0", pc, redirect, count); end
      checks++; if ({upd_en, upd_idx, upd_taken} !== {1'b1, 5'd16, 1'b1}) begin errors++;
         $display("FAIL mp_upd en=%b idx=%0d tk=%b want 1 16 1", upd_en, upd_idx, upd_taken); end
      idle(); tick();
      checks++; if (redirect !== 1'b0 || upd_en !== 1'b0 || pc !== 64'h204) begin errors++;
         $display("FAIL mp_pulse rd=%b en=%b pc=%h want 0 0 204", redirect, upd_en, pc); end
   endtask

   task automatic test_queue_full();
      is_branch = 1; pred_taken = 0;
      for (int k = 0; k < DEPTH; k++) tick();
      checks++; if (count !== 3'd4 || pc !== 64'h214) begin errors++;
         $display("FAIL qf_fill count=%0d pc=%h want 4 214", count, pc); end
      #1;
      checks++; if (fetch_fire !== 1'b0) begin errors++; $display("FAIL qf_block fire=%b want 0", fetch_fire); end
      res_valid = 1; res_taken = 0; tick();
      checks++; if (pc !== 64'h214 || count !== 3'd3 || upd_en !== 1'b1 || redirect !== 1'b0) begin errors++;
         $display("FAIL qf_pop pc=%h count=%0d en=%b rd=%b want 214 3 1 0", pc, count, upd_en, redirect); end
      res_valid = 0; #1;
      checks++; if (fetch_fire !== 1'b1) begin errors++; $display("FAIL qf_accept fire=%b want 1", fetch_fire); end
      tick();
      checks++; if (pc !== 64'h218 || count !== 3'd4) begin errors++;
         $display("FAIL qf_refill pc=%h count=%0d want 218 4", pc, count); end
   endtask

   task automatic test_back_to_back();
      idle(); res_valid = 1; res_taken = 0; tick();
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL bb_pop count=%0d want 3", count); end
      res_taken = 1; res_target = 64'h300; is_branch = 1; pred_taken = 1; pred_target = 64'h500; #1;
      checks++; if (fetch_fire !== 1'b1) begin errors++; $display("FAIL bb_fire fire=%b want 1", fetch_fire); end
      tick();
      checks++; if (pc !== 64'h300 || count !== 3'd0 || redirect !== 1'b1) begin errors++;
         $display("FAIL bb_drop pc=%h count=%0d rd=%b want 300 0 1", pc, count, redirect); end
      idle(); is_branch = 1; tick();
      idle(); stall = 1; is_branch = 1; res_valid = 1; res_taken = 1; res_target = 64'h300; tick();
      checks++; if (pc !== 64'h300 || redirect !== 1'b1 || count !== 3'd0 || upd_en !== 1'b1) begin errors++;
         $display("FAIL bb_stall pc=%h rd=%b count=%0d en=%b want 300 1 0 1", pc, redirect, count, upd_en); end
      idle();
   endtask

   task automatic test_err_reset();
      idle(); res_valid = 1; tick();
      checks++; if (err !== 1'b1 || upd_en !== 1'b0 || redirect !== 1'b0) begin errors++;
         $display("FAIL er_set err=%b en=%b rd=%b want 1 0 0", err, upd_en, redirect); end
      idle(); is_branch = 1; tick(); tick();
      checks++; if (err !== 1'b1 || count !== 3'd2) begin errors++;
         $display("FAIL er_sticky err=%b count=%0d want 1 2", err, count); end
      idle(); rst = 1; is_branch = 1; res_valid = 1; tick();
      checks++; if (err !== 1'b0 || count !== 3'd0 || pc !== 64'h0 || upd_en !== 1'b0) begin errors++;
         $display("FAIL er_rst err=%b count=%0d pc=%h en=%b want 0 0 0 0", err, count, pc, upd_en); end
      idle();
   endtask

   task automatic test_random();
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         stall = ($urandom_range(0, 4) == 0);
         is_branch = ($urandom_range(0, 9) < 4);
         pred_taken = $urandom_range(0, 1);
         pred_target = {32'h0, $urandom_range(0, 4095), 2'b00};
         res_valid = ($urandom_range(0, 9) < 3);
         res_taken = $urandom_range(0, 1);
         res_target = (mq.size() > 0 && $urandom_range(0, 1)) ? mq[0].pn : {32'h0, $urandom_range(0, 4095), 2'b00};
         #1;
         checks++; if (pred_idx !== m_pc[6:2]) begin errors++; $display("FAIL rnd_idx got %0d want %0d", pred_idx, m_pc[6:2]); end
         checks++; if (fetch_fire !== (!stall && !(is_branch && mq.size() == DEPTH))) begin errors++;
            $display("FAIL rnd_fire got %b", fetch_fire); end
         tick();
         checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc got %h want %h", pc, m_pc); end
         checks++; if (count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count got %0d want %0d", count, mq.size()); end
         checks++; if (upd_en !== m_upd_en || redirect !== m_redirect || err !== m_err) begin errors++;
            $display("FAIL rnd_flags got en=%b rd=%b err=%b want %b %b %b", upd_en, redirect, err, m_upd_en, m_redirect, m_err); end
         if (m_upd_en) begin
            checks++; if (upd_idx !== m_upd_idx || upd_taken !== m_upd_taken) begin errors++;
               $display("FAIL rnd_upd got idx=%0d tk=%b want %0d %b", upd_idx, upd_taken, m_upd_idx, m_upd_taken); end
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_taken_correct();
      test_mispredict();
      test_queue_full();
      test_back_to_back();
      test_err_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
